// File: rtl/hazard_scoreboard.sv
// LC-3b decode-stage hazard controller: per-register/CC pending-writer counters, dependency and branch-shadow stalls, AGEX valid.
// Optional macro HAZARD_STATS_EN adds saturating dep_stall_cnt / br_stall_cnt outputs.
module hazard_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int MAX_PEND = 3,
  parameter int CNT_W    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       de_v,
  input  logic [2:0] de_sr1_id,
  input  logic       de_sr1_needed,
  input  logic [2:0] de_sr2_id,
  input  logic       de_sr2_needed,
  input  logic [2:0] de_dr_id,
  input  logic       de_ld_reg,
  input  logic       de_ld_cc,
  input  logic       de_uses_cc,
  input  logic       de_br_op,
  input  logic       br_resolved,
  input  logic       sr_v_ld_reg,
  input  logic [2:0] sr_drid,
  input  logic       sr_v_ld_cc,
  input  logic       mem_stall,
  output logic       dep_stall,
  output logic       v_de_br_stall,
  output logic       ld_de,
  output logic       ld_agex,
  output logic       agex_v,
  output logic       issue,
  output logic       sb_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] dep_stall_cnt,
  output logic [15:0] br_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  typedef enum logic {ST_RUN = 1'b0, ST_BR_WAIT = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_pend [NUM_REGS];
  logic [CNT_W-1:0]    r_cc_pend;
  logic                r_agex_v;
  logic                r_sb_err;
  logic                w_run, w_hazard, w_dep, w_issue;
  logic [NUM_REGS-1:0] w_inc, w_dec, w_underflow;
  logic                w_cc_inc, w_cc_dec, w_err_set;

  // Retire does not bypass: hazards look only at the registered counters.
  always_comb begin
    w_run    = (r_state == ST_RUN);
    w_hazard = (de_sr1_needed && (r_pend[de_sr1_id] != '0)) ||
               (de_sr2_needed && (r_pend[de_sr2_id] != '0)) ||
               (de_uses_cc    && (r_cc_pend != '0))         ||
               (de_ld_reg     && (r_pend[de_dr_id] == PEND_MAX)) ||
               (de_ld_cc      && (r_cc_pend == PEND_MAX));
    w_dep    = de_v & w_run & w_hazard;
    w_issue  = de_v & w_run & ~w_dep & ~mem_stall;
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r]       = w_issue & de_ld_reg & (de_dr_id == 3'(r));
      w_dec[r]       = sr_v_ld_reg & (sr_drid == 3'(r));
      w_underflow[r] = w_dec[r] & (r_pend[r] == '0);
    end
    w_cc_inc  = w_issue & de_ld_cc;
    w_cc_dec  = sr_v_ld_cc;
    w_err_set = (|w_underflow) | (w_cc_dec & (r_cc_pend == '0)) | (br_resolved & w_run);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_pend[r] <= '0;
      r_cc_pend <= '0;
      r_agex_v  <= 1'b0;
      r_sb_err  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] && !w_dec[r])
          r_pend[r] <= r_pend[r] + PEND_ONE;
        else if (!w_inc[r] && w_dec[r] && (r_pend[r] != '0))
          r_pend[r] <= r_pend[r] - PEND_ONE;
      end
      if (w_cc_inc && !w_cc_dec)
        r_cc_pend <= r_cc_pend + PEND_ONE;
      else if (!w_cc_inc && w_cc_dec && (r_cc_pend != '0))
        r_cc_pend <= r_cc_pend - PEND_ONE;
      if (!mem_stall) r_agex_v <= w_issue;
      if (w_err_set)  r_sb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RUN;
    else          r_state <= w_state_nxt;
  end

  // br_resolved is honoured in BR_WAIT even while MEM is stalled.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_issue && de_br_op) w_state_nxt = ST_BR_WAIT;
      ST_BR_WAIT: if (br_resolved)         w_state_nxt = ST_RUN;
      default:                             w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    dep_stall     = w_dep;
    issue         = w_issue;
    ld_agex       = ~mem_stall;
    ld_de         = ~mem_stall & ~w_dep;
    v_de_br_stall = ~w_run | (de_v & de_br_op & w_run);
    agex_v        = r_agex_v;
    sb_err        = r_sb_err;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_dep_stall_cnt, r_br_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dep_stall_cnt <= '0;
      r_br_stall_cnt  <= '0;
    end else begin
      if (dep_stall && (r_dep_stall_cnt != 16'hFFFF))
        r_dep_stall_cnt <= r_dep_stall_cnt + 16'd1;
      if (v_de_br_stall && (r_br_stall_cnt != 16'hFFFF))
        r_br_stall_cnt <= r_br_stall_cnt + 16'd1;
    end
  end

  assign dep_stall_cnt = r_dep_stall_cnt;
  assign br_stall_cnt  = r_br_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written corner sequences, and random traffic against a counter model.
module tb_hazard_scoreboard;

  typedef struct packed {
    logic       de_v;
    logic       sr1n;
    logic [2:0] sr1;
    logic       sr2n;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       ld_reg;
    logic       ld_cc;
    logic       uses_cc;
    logic       br_op;
    logic       br_res;
    logic       sr_ld;
    logic [2:0] sr_drid;
    logic       sr_ld_cc;
    logic       mem;
  } in_t;

  // exp = {dep_stall, v_de_br_stall, issue, agex_v, sb_err}
  typedef struct {
    in_t        in;
    logic [4:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  in_t  cur = '0;
  logic dep_stall, v_de_br_stall, ld_de, ld_agex, agex_v, issue, sb_err;
`ifdef HAZARD_STATS_EN
  logic [15:0] dep_stall_cnt, br_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .de_v(cur.de_v), .de_sr1_id(cur.sr1), .de_sr1_needed(cur.sr1n),
    .de_sr2_id(cur.sr2), .de_sr2_needed(cur.sr2n),
    .de_dr_id(cur.dr), .de_ld_reg(cur.ld_reg), .de_ld_cc(cur.ld_cc),
    .de_uses_cc(cur.uses_cc), .de_br_op(cur.br_op), .br_resolved(cur.br_res),
    .sr_v_ld_reg(cur.sr_ld), .sr_drid(cur.sr_drid), .sr_v_ld_cc(cur.sr_ld_cc),
    .mem_stall(cur.mem),
    .dep_stall(dep_stall), .v_de_br_stall(v_de_br_stall), .ld_de(ld_de),
    .ld_agex(ld_agex), .agex_v(agex_v), .issue(issue), .sb_err(sb_err)
`ifdef HAZARD_STATS_EN
    , .dep_stall_cnt(dep_stall_cnt), .br_stall_cnt(br_stall_cnt)
`endif
  );

  // Reference model: in-flight writer counts as plain integers.
  int m_pend [8];
  int m_cc;
  bit m_brw, m_agex, m_err;
  int m_dep_cnt, m_br_cnt;
  bit e_dep, e_issue, e_brst;

  function automatic in_t mk(input logic de_v, input logic ld_reg, input logic [2:0] dr,
                             input logic sr1n, input logic [2:0] sr1,
                             input logic sr2n, input logic [2:0] sr2,
                             input logic ld_cc, input logic uses_cc, input logic br_op,
                             input logic br_res, input logic sr_ld, input logic [2:0] sr_drid,
                             input logic sr_ld_cc, input logic mem);
    in_t v;
    v.de_v = de_v; v.ld_reg = ld_reg; v.dr = dr; v.sr1n = sr1n; v.sr1 = sr1;
    v.sr2n = sr2n; v.sr2 = sr2; v.ld_cc = ld_cc; v.uses_cc = uses_cc;
    v.br_op = br_op; v.br_res = br_res; v.sr_ld = sr_ld; v.sr_drid = sr_drid;
    v.sr_ld_cc = sr_ld_cc; v.mem = mem;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_cc = 0; m_brw = 0; m_agex = 0; m_err = 0;
    m_dep_cnt = 0; m_br_cnt = 0;
  endtask

  task automatic model_eval(input in_t v);
    bit run;
    run     = !m_brw;
    e_dep   = v.de_v && run &&
              ((v.sr1n && m_pend[v.sr1] > 0) || (v.sr2n && m_pend[v.sr2] > 0) ||
               (v.uses_cc && m_cc > 0) || (v.ld_reg && m_pend[v.dr] >= 3) ||
               (v.ld_cc && m_cc >= 3));
    e_issue = v.de_v && run && !e_dep && !v.mem;
    e_brst  = m_brw || (v.de_v && v.br_op && run);
  endtask

  task automatic model_update(input in_t v);
    if (v.sr_ld && m_pend[v.sr_drid] == 0) m_err = 1;
    if (v.sr_ld_cc && m_cc == 0) m_err = 1;
    if (!m_brw && v.br_res) m_err = 1;
    if (e_issue && v.ld_reg) m_pend[v.dr]++;
    if (v.sr_ld && m_pend[v.sr_drid] > 0) m_pend[v.sr_drid]--;
    if (e_issue && v.ld_cc) m_cc++;
    if (v.sr_ld_cc && m_cc > 0) m_cc--;
    if (m_brw) begin
      if (v.br_res) m_brw = 0;
    end else if (e_issue && v.br_op) m_brw = 1;
    if (!v.mem) m_agex = e_issue;
    if (e_dep && m_dep_cnt < 65535) m_dep_cnt++;
    if (e_brst && m_br_cnt < 65535) m_br_cnt++;
  endtask

  // Apply inputs just after a rising edge, compare everything on the falling edge.
  task automatic drive_and_check(input in_t v, input string tag);
    cur = v;
    @(negedge clk);
    model_eval(v);
    chk({tag, ".dep_stall"},     dep_stall,     e_dep);
    chk({tag, ".issue"},         issue,         e_issue);
    chk({tag, ".v_de_br_stall"}, v_de_br_stall, e_brst);
    chk({tag, ".ld_agex"},       ld_agex,       !v.mem);
    chk({tag, ".ld_de"},         ld_de,         !v.mem && !e_dep);
    chk({tag, ".agex_v"},        agex_v,        m_agex);
    chk({tag, ".sb_err"},        sb_err,        m_err);
`ifdef HAZARD_STATS_EN
    chk({tag, ".dep_stall_cnt"}, dep_stall_cnt, m_dep_cnt);
    chk({tag, ".br_stall_cnt"},  br_stall_cnt,  m_br_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(cur);
    #1;
  endtask

  function automatic in_t rand_in();
    in_t v;
    int  r;
    v = in_t'({$urandom, $urandom});
    v.de_v     = ($urandom_range(3) != 0);
    v.br_op    = ($urandom_range(7) == 0);
    v.mem      = ($urandom_range(5) == 0);
    v.br_res   = m_brw ? ($urandom_range(2) == 0) : ($urandom_range(99) == 0);
    r          = $urandom_range(7);
    v.sr_drid  = 3'(r);
    v.sr_ld    = (m_pend[r] > 0) ? ($urandom_range(1) == 0) : ($urandom_range(63) == 0);
    v.sr_ld_cc = (m_cc > 0) ? ($urandom_range(1) == 0) : ($urandom_range(63) == 0);
    return v;
  endfunction

  vec_t tv [26];
  in_t  idle, w_r0, w_r3, w_r7, br, rd_r3;

  initial begin
    idle  = '0;
    w_r0  = mk(1,1,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0);
    w_r3  = mk(1,1,3, 0,0, 0,0, 0,0,0,0, 0,0,0,0);
    w_r7  = mk(1,1,7, 0,0, 0,0, 0,0,0,0, 0,0,0,0);
    br    = mk(1,0,0, 0,0, 0,0, 0,0,1,0, 0,0,0,0);
    rd_r3 = mk(1,0,0, 1,3, 0,0, 0,0,0,0, 0,0,0,0);

    tv[0]  = '{mk(1,1,3, 1,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00100}; // ADD R3 issues
    tv[1]  = '{mk(1,1,4, 1,3, 0,0, 0,0,0,0, 1,3,0,0), 5'b10010}; // reads R3, retire same cycle: still stalls
    tv[2]  = '{mk(1,1,4, 1,3, 0,0, 0,0,0,0, 0,0,0,0), 5'b00100};
    tv[3]  = '{mk(1,1,5, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00110};
    tv[4]  = '{mk(1,1,5, 0,0, 0,0, 0,0,0,0, 1,5,0,0), 5'b00110}; // inc+dec R5: stays 1
    tv[5]  = '{mk(1,0,0, 0,0, 1,5, 0,0,0,0, 0,0,0,0), 5'b10010};
    tv[6]  = '{mk(0,0,0, 0,0, 0,0, 0,0,0,0, 1,5,0,0), 5'b00000};
    tv[7]  = '{mk(0,0,0, 0,0, 0,0, 0,0,0,0, 1,4,0,0), 5'b00000};
    tv[8]  = '{mk(1,1,2, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00100};
    tv[9]  = '{mk(1,1,2, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00110};
    tv[10] = '{mk(1,1,2, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00110};
    tv[11] = '{mk(1,1,2, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b10010}; // fourth writer to R2
    tv[12] = '{mk(1,1,2, 0,0, 0,0, 0,0,0,0, 1,2,0,0), 5'b10000};
    tv[13] = '{mk(1,1,2, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00100};
    tv[14] = '{mk(0,0,0, 0,0, 0,0, 0,0,0,0, 1,2,0,0), 5'b00010};
    tv[15] = '{mk(0,0,0, 0,0, 0,0, 0,0,0,0, 1,2,0,0), 5'b00000};
    tv[16] = '{mk(0,0,0, 0,0, 0,0, 0,0,0,0, 1,2,0,0), 5'b00000};
    tv[17] = '{mk(1,0,0, 0,0, 0,0, 1,0,0,0, 0,0,0,0), 5'b00100}; // CC writer
    tv[18] = '{mk(1,0,0, 0,0, 0,0, 0,1,1,0, 0,0,0,0), 5'b11010}; // BR waits on CC
    tv[19] = '{mk(1,0,0, 0,0, 0,0, 0,1,1,0, 0,0,1,0), 5'b11000};
    tv[20] = '{mk(1,0,0, 0,0, 0,0, 0,1,1,0, 0,0,0,0), 5'b01100}; // BR issues
    tv[21] = '{mk(1,1,6, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b01010}; // ignored in BR_WAIT
    tv[22] = '{mk(1,1,6, 0,0, 0,0, 0,0,0,1, 0,0,0,1), 5'b01000}; // resolve under mem_stall
    tv[23] = '{mk(1,1,6, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00100};
    tv[24] = '{mk(0,0,0, 0,0, 0,0, 0,0,0,1, 0,0,0,0), 5'b00010}; // stray resolve in RUN
    tv[25] = '{mk(0,0,0, 0,0, 0,0, 0,0,0,0, 0,0,0,0), 5'b00001};

    model_reset();
    @(posedge clk); #1;
    drive_and_check(idle, "reset");
    chk("reset.agex_v_const", agex_v, 0);
    chk("reset.sb_err_const", sb_err, 0);
    reset_n = 1'b1;
    tick();

    foreach (tv[i]) begin
      drive_and_check(tv[i].in, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table", i), {dep_stall, v_de_br_stall, issue, agex_v, sb_err}, tv[i].exp);
      tick();
    end

    // mem_stall freezes issue and holds agex_v
    drive_and_check(w_r0, "ms0"); chk("ms0.issue", issue, 1); tick();
    for (int k = 0; k < 2; k++) begin
      in_t v;
      v = w_r7; v.mem = 1'b1;
      drive_and_check(v, "ms_stall");
      chk("ms_stall.issue", issue, 0);
      chk("ms_stall.ld_agex", ld_agex, 0);
      chk("ms_stall.agex_v_hold", agex_v, 1);
      tick();
    end
    drive_and_check(w_r7, "ms_rel"); chk("ms_rel.issue", issue, 1); tick();
    drive_and_check(idle, "ms_after"); chk("ms_after.agex_v", agex_v, 1); tick();

    // Asynchronous reset with pend[3]=2, BR_WAIT, agex_v=1
    drive_and_check(w_r3, "rs0"); tick();
    drive_and_check(w_r3, "rs1"); tick();
    drive_and_check(br, "rs2"); chk("rs2.issue", issue, 1); tick();
    drive_and_check(rd_r3, "rs3"); chk("rs3.agex_v", agex_v, 1); chk("rs3.br_wait", v_de_br_stall, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("arst.agex_v", agex_v, 0);
    chk("arst.sb_err", sb_err, 0);
    chk("arst.v_de_br_stall", v_de_br_stall, 0);
    chk("arst.dep_stall", dep_stall, 0);
    cur = idle;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
      end
      drive_and_check(rand_in(), "rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
